if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC register and drives the byte address into the combinational, big-endian, byte-addressed 16 KB instruction memory. Consumes the 32-bit word that memory returns.
- Selects the next PC from sequential, branch, jump or jr sources, and holds the IF/ID pipeline register that feeds decode.
- Handles stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- IMEM_BYTES, 16384, instruction memory size in bytes. Used for range checking.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID for bubbles and faults.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- imem_pc  out  32  byte address to instruction memory; equals pc
- imem_instr  in  32  instruction word returned combinationally for imem_pc
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  replace IF/ID contents with a bubble
- branch_en  in  1  taken branch resolved in ID
- branch_base  in  32  PC+4 of the branch instruction
- branch_offset  in  16  signed word offset
- jump_en  in  1  j instruction in ID
- jump_index  in  26  j target index
- jr_en  in  1  jr instruction in ID
- jr_addr  in  32  register target for jr
- pc  out  32  current PC
- if_id_instr  out  32  registered instruction
- if_id_pc4  out  32  registered PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_fault  out  1  fetched PC was misaligned or out of range

Behaviour:
- Reset values, applied on the first rising edge with rst=1:
  - pc=RESET_PC
  - if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, if_id_fault=0
  - rst overrides every other input.
- imem_pc = pc. Fetch is zero-latency combinational; the instruction is registered into IF/ID on the next edge.
- redirect = jr_en | jump_en | branch_en.
- Redirect target priority:
  - jr: jr_addr
  - jump: {if_id_pc4[31:28], jump_index, 2'b00}
  - branch: branch_base + (sign_extend(branch_offset) << 2), 32-bit wraparound
- PC update priority: rst > redirect > stall (hold) > pc+4. pc+4 wraps modulo 2^32.
- IF/ID update priority:
  - rst: reset values.
  - flush or redirect: bubble (instr=NOP_INSTR, valid=0, fault=0, pc4 unchanged).
  - stall: hold all fields.
  - Otherwise: capture. instr=imem_instr, or NOP_INSTR if fault; pc4=pc+4; valid=1; fault=fetch_fault.
- fetch_fault = (pc[1:0]!=0) | (pc > IMEM_BYTES-4). Fault does not stop fetch; PC keeps advancing.
- Simultaneous events:
  - Redirect with stall: redirect wins; PC takes the target and IF/ID is bubbled.
  - Flush with stall and no redirect: PC holds and IF/ID is bubbled.
  - Multiple redirect enables: apply the priority above; no error is raised.
- Reset mid-stall or mid-redirect: reset wins on that edge; fetch resumes at RESET_PC the following cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds three 32-bit outputs reset to 0:
  - perf_fetched: increments on each edge that captures with valid=1.
  - perf_stalled: increments on each edge with stall=1 and no redirect or rst.
  - perf_flushed: increments on each edge that bubbles due to flush or redirect.
  - All counters wrap at 2^32.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package mips_fetch_pkg holds:
  - NOP_INSTR, the default RESET_PC and IMEM_BYTES constants.
  - typedef next_pc_sel_e {SEL_SEQ, SEL_HOLD, SEL_BRANCH, SEL_JUMP, SEL_JR, SEL_RESET}.
  - typedef if_id_t struct {instr, pc4, valid, fault}.
- One combinational sub-module, if_next_pc: computes the branch and jump targets and the selected next PC. The top level holds the PC and IF/ID registers and the optional counters.

Test Plan:
- Reset and sequential fetch, RESET_PC=100: rst 2 cycles, then release → pc 100,104,108. After the first edge, if_id_instr=0x48080000, if_id_pc4=104, valid=1.
- Branch redirect: branch_en=1, branch_base=520, branch_offset=0xFFFB → next pc=500; IF/ID bubble (valid=0, instr=0).
- Jump and jr priority:
  - if_id_pc4=1104, jump_en=1, jump_index=3 → pc=12.
  - Same cycle with jr_en=1 and jr_addr=1500 → pc=1500.
- Stall: stall=1 for 2 cycles at pc=208 → pc stays 208 and IF/ID holds. Then stall=1 with flush=1 → IF/ID valid=0 and pc still 208.
- Fault: pc=16382 → if_id_fault=1, if_id_instr=0, pc advances to 16386. Separately, jr_addr=102 → fault=1 on the next capture.
- Reset mid-redirect: branch_en=1 and rst=1 on the same edge → pc=RESET_PC, all IF/ID fields at reset values. With FETCH_PERF_CNT_EN, all counters are 0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Contents:
//   DEFAULT_RESET_PC, DEFAULT_IMEM_BYTES, NOP_INSTR : default constants
//   next_pc_sel_e : source chosen for the next PC value
//   if_id_t       : contents of the IF/ID pipeline register
package mips_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'd0;
  localparam int          DEFAULT_IMEM_BYTES = 16384;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JR,
    SEL_RESET
  } next_pc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the combinational,
// big-endian, byte-addressed instruction memory.
// Signals:
//   imem_pc    : byte address driven by the fetch stage
//   imem_instr : 32-bit word returned combinationally for imem_pc
// Modports:
//   master : fetch stage side (drives the address)
//   slave  : memory side (returns the word)
interface if_fetch_stage_if;

  logic [31:0] imem_pc;
  logic [31:0] imem_instr;

  modport master (output imem_pc, input imem_instr);
  modport slave  (input imem_pc, output imem_instr);

endinterface

// File: rtl/if_next_pc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   rst, stall         : reset and hazard hold
//   pc, if_id_pc4      : current PC and the PC+4 held in IF/ID (jump region)
//   branch_*           : taken branch, base (PC+4 of branch) and word offset
//   jump_en/jump_index : j instruction target
//   jr_en/jr_addr      : jr register target
//   next_pc            : value the PC register loads on the next edge
//   redirect           : any of jr/jump/branch is requesting a redirect
module if_next_pc
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc4,
  input  logic        branch_en,
  input  logic [31:0] branch_base,
  input  logic [15:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0]  branch_target;
  logic [31:0]  jump_target;
  next_pc_sel_e sel;

  // Sign-extended word offset shifted into a byte offset; wraps at 2^32.
  assign branch_target = branch_base + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_target   = {if_id_pc4[31:28], jump_index, 2'b00};
  assign redirect      = jr_en | jump_en | branch_en;

  always_comb begin
    sel = SEL_SEQ;
    if (rst)            sel = SEL_RESET;
    else if (jr_en)     sel = SEL_JR;
    else if (jump_en)   sel = SEL_JUMP;
    else if (branch_en) sel = SEL_BRANCH;
    else if (stall)     sel = SEL_HOLD;

    next_pc = pc + 32'd4;
    case (sel)
      SEL_RESET:  next_pc = RESET_PC;
      SEL_JR:     next_pc = jr_addr;
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = branch_target;
      SEL_HOLD:   next_pc = pc;
      default:    next_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the pipelined MIPS core. Holds the PC and the
// IF/ID pipeline register, fetches from a combinational instruction memory
// and applies stall/flush/redirect from the hazard unit and ID stage.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   imem               : instruction-memory bus (master side)
//   stall, flush       : hold PC and IF/ID / bubble IF/ID
//   branch_*, jump_*, jr_* : redirect requests resolved in ID
//   pc                 : current PC
//   if_id_*            : IF/ID register contents for decode
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_fetched, perf_stalled, perf_flushed : 32-bit wrapping event counters
module if_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_BYTES = DEFAULT_IMEM_BYTES,
  parameter logic [31:0] NOP_INSTR  = mips_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_stage_if.master imem,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_en,
  input  logic [31:0] branch_base,
  input  logic [15:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        if_id_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled,
  output logic [31:0] perf_flushed
`endif
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  logic [31:0] pc_q;
  if_id_t      if_id_q;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] pc4;
  logic        fetch_fault;

  assign pc4         = pc_q + 32'd4;
  assign fetch_fault = (pc_q[1:0] != 2'b00) | (pc_q > LAST_WORD);

  assign imem.imem_pc = pc_q;
  assign pc           = pc_q;
  assign if_id_instr  = if_id_q.instr;
  assign if_id_pc4    = if_id_q.pc4;
  assign if_id_valid  = if_id_q.valid;
  assign if_id_fault  = if_id_q.fault;

  if_next_pc #(.RESET_PC(RESET_PC)) u_next_pc (
    .rst           (rst),
    .stall         (stall),
    .pc            (pc_q),
    .if_id_pc4     (if_id_q.pc4),
    .branch_en     (branch_en),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_index    (jump_index),
    .jr_en         (jr_en),
    .jr_addr       (jr_addr),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  // A bubble keeps pc4 so a later jump still sees the last real PC region.
  // A faulting fetch still advances; its word is replaced by a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0, fault: 1'b0};
    end else begin
      pc_q <= next_pc;
      if (flush | redirect) begin
        if_id_q.instr <= NOP_INSTR;
        if_id_q.valid <= 1'b0;
        if_id_q.fault <= 1'b0;
      end else if (!stall) begin
        if_id_q <= '{instr: (fetch_fault ? NOP_INSTR : imem.imem_instr),
                     pc4:   pc4,
                     valid: 1'b1,
                     fault: fetch_fault};
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // A stall that coincides with a flush counts as both stalled and flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_stalled <= 32'd0;
      perf_flushed <= 32'd0;
    end else begin
      if (flush | redirect)
        perf_flushed <= perf_flushed + 32'd1;
      else if (!stall)
        perf_fetched <= perf_fetched + 32'd1;
      if (stall && !redirect)
        perf_stalled <= perf_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard testbench for if_fetch_stage. A behavioural model predicts the
// state after every clock edge; the prediction is queued and a separate
// monitor compares it with the DUT shortly after the edge.
module tb_if_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'd100;
  localparam int          TB_IMEM     = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        branch_en, jump_en, jr_en;
  logic [31:0] branch_base, jr_addr;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        if_id_valid, if_id_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stalled, perf_flushed;
`endif

  int tests = 0;
  int fails = 0;

  if_fetch_stage_if fetch_bus();

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed word at 100, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd100) return 32'h4808_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always_comb fetch_bus.imem_instr = mem_word(fetch_bus.imem_pc);

  if_fetch_stage #(.RESET_PC(TB_RESET_PC), .IMEM_BYTES(TB_IMEM), .NOP_INSTR(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (fetch_bus.master),
    .stall         (stall),
    .flush         (flush),
    .branch_en     (branch_en),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_index    (jump_index),
    .jr_en         (jr_en),
    .jr_addr       (jr_addr),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .if_id_fault   (if_id_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalled  (perf_stalled),
    .perf_flushed  (perf_flushed)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
    logic [31:0] n_fetched;
    logic [31:0] n_stalled;
    logic [31:0] n_flushed;
  } exp_t;

  exp_t exp_q[$];

  // Model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fault;
  logic [31:0] m_fetched, m_stalled, m_flushed;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge state, and advance.
  task automatic applyStimulus(input logic r, input logic st, input logic fl,
                               input logic b_en, input logic [31:0] b_base, input logic [15:0] b_off,
                               input logic j_en, input logic [25:0] j_idx,
                               input logic r_en, input logic [31:0] r_addr);
    exp_t e;
    logic [31:0] target;
    logic        redir, flt;
    int          offs;
    rst = r; stall = st; flush = fl;
    branch_en = b_en; branch_base = b_base; branch_offset = b_off;
    jump_en = j_en; jump_index = j_idx; jr_en = r_en; jr_addr = r_addr;

    redir = r_en || j_en || b_en;
    offs  = $signed(b_off);
    if (r_en)      target = r_addr;
    else if (j_en) target = (m_pc4 & 32'hF000_0000) | (32'(j_idx) * 4);
    else           target = b_base + 32'(offs * 4);
    flt = (m_pc % 4 != 0) || (m_pc > 32'(TB_IMEM - 4));

    if (r) begin
      m_pc = TB_RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
      m_fetched = 0; m_stalled = 0; m_flushed = 0;
    end else begin
      if (st && !redir) m_stalled++;
      if (fl || redir) begin
        m_instr = 0; m_valid = 0; m_fault = 0;
        m_flushed++;
      end else if (!st) begin
        m_instr = flt ? 32'h0 : mem_word(m_pc);
        m_pc4   = m_pc + 4;
        m_valid = 1;
        m_fault = flt;
        m_fetched++;
      end
      if (redir)    m_pc = target;
      else if (!st) m_pc = m_pc + 4;
    end

    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.fault = m_fault;
    e.n_fetched = m_fetched; e.n_stalled = m_stalled; e.n_flushed = m_flushed;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jr_to(input logic [31:0] a);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
  endtask

  // Monitor: compares the oldest prediction against the DUT after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc", pc, e.pc);
        checkOutput("imem_pc", fetch_bus.imem_pc, e.pc);
        checkOutput("if_id_instr", if_id_instr, e.instr);
        checkOutput("if_id_pc4", if_id_pc4, e.pc4);
        checkOutput("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        checkOutput("if_id_fault", {31'd0, if_id_fault}, {31'd0, e.fault});
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetched", perf_fetched, e.n_fetched);
        checkOutput("perf_stalled", perf_stalled, e.n_stalled);
        checkOutput("perf_flushed", perf_flushed, e.n_flushed);
`endif
      end
    end
  end

  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
    m_fetched = 0; m_stalled = 0; m_flushed = 0;

    // Reset and sequential fetch from 100
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycle();
    idle_cycle();
    idle_cycle();

    // Branch back: 520 + (-5 << 2) = 500
    applyStimulus(0, 0, 0, 1, 32'd520, 16'hFFFB, 0, 0, 0, 0);
    idle_cycle();

    // Jump region taken from if_id_pc4 = 1104, then jr beating jump
    jr_to(32'd1100);
    idle_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 26'd3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 26'd3, 1, 32'd1500);
    applyStimulus(0, 0, 0, 1, 32'd40, 16'h0004, 1, 26'd7, 0, 0);
    idle_cycle();

    // Stall at 208, then stall with flush
    jr_to(32'd204);
    idle_cycle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 32'd300, 16'h0002, 0, 0, 0, 0);
    idle_cycle();

    // Faults: out of range / misaligned
    jr_to(32'd16382);
    idle_cycle();
    idle_cycle();
    jr_to(32'd16380);
    idle_cycle();
    idle_cycle();
    jr_to(32'd102);
    idle_cycle();

    // PC wraparound
    jr_to(32'hFFFF_FFFC);
    idle_cycle();
    idle_cycle();

    // Reset coinciding with a redirect and a stall
    applyStimulus(1, 1, 0, 1, 32'd520, 16'hFFFB, 0, 0, 0, 0);
    idle_cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ja;
      ja = ($urandom_range(0, 9) == 0) ? $urandom() : (32'($urandom_range(0, 4200)) << 2);
      if ($urandom_range(0, 15) == 0) ja = ja | 32'd2;
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 16000), 16'($urandom()),
                    $urandom_range(0, 11) == 0, 26'($urandom()),
                    $urandom_range(0, 11) == 0, ja);
    end
    idle_cycle();

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
